// File: rtl/afifo_pkg.sv
// Shared types and defaults for the async-FIFO read-side consumer.
package afifo_pkg;

  localparam int DATA_WIDTH = 8;

  typedef logic [DATA_WIDTH-1:0] afifo_word_t;
  typedef logic [1:0]            occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/afifo_reader_if.sv
// FIFO-pop and valid/ready stream signals of the read-domain consumer.
interface afifo_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  rd_en;
  logic                  rempty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rinc;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;
  logic [CNT_WIDTH-1:0]  rd_count;

  modport master (
    input  rd_en, rempty, rdata, m_ready,
    output rinc, m_valid, m_data, rd_count
  );

  modport slave (
    output rd_en, rempty, rdata, m_ready,
    input  rinc, m_valid, m_data, rd_count
  );
endinterface

// File: rtl/afifo_skid_buf.sv
// Two-entry skid buffer: slot0 is the presented head, slot1 absorbs one word
// popped while the head is stalled.
module afifo_skid_buf
  import afifo_pkg::*;
#(
  parameter int DATA_WIDTH = afifo_pkg::DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  m_ready_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output occ_t                  occ_o
);

  occ_t                  occ_q, occ_d;
  logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
  logic                  deq;

  assign m_valid_o = (occ_q != OCC_EMPTY);
  assign m_data_o  = slot0_q;
  assign occ_o     = occ_q;
  assign deq       = m_valid_o & m_ready_i;

  always_comb begin
    occ_d   = occ_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (push_i) begin
          slot0_d = data_i;
          occ_d   = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (push_i && !deq) begin
          slot1_d = data_i;
          occ_d   = OCC_FULL;
        end else if (push_i && deq) begin
          slot0_d = data_i;
        end else if (deq) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (deq) begin
          slot0_d = slot1_q;
          occ_d   = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q   <= OCC_EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      occ_q   <= occ_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

endmodule

// File: rtl/afifo_reader.sv
// Read-domain FIFO consumer: pops into a skid buffer, streams out valid/ready,
// and counts popped words.
module afifo_reader
  import afifo_pkg::*;
#(
  parameter int DATA_WIDTH = afifo_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic           rclk,
  input  logic           rrst_n,
  afifo_reader_if.master bus
);

  occ_t                 occ;
  logic                 rinc;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Reset gates rinc combinationally so the pop strobe drops as soon as
  // rrst_n falls, not at the next edge.
  assign rinc = rrst_n & bus.rd_en & ~bus.rempty & (occ != OCC_FULL);

  assign bus.rinc     = rinc;
  assign bus.rd_count = cnt_q;

  afifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk_i    (rclk),
    .rst_ni   (rrst_n),
    .push_i   (rinc),
    .data_i   (bus.rdata),
    .m_ready_i(bus.m_ready),
    .m_valid_o(bus.m_valid),
    .m_data_o (bus.m_data),
    .occ_o    (occ)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (rinc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: doc/afifo_reader.md
Name: afifo_reader

Overview:
- Read-side consumer for the asynchronous FIFO, clocked entirely in the read domain.
- Pops the FIFO through the rinc/rdata/rempty port and presents the words as a valid/ready stream to downstream logic.
- A 2-entry skid buffer gives full throughput with no combinational path from m_ready to rinc.
- Counts popped words for scoreboard and debug visibility.

Parameters:
- DATA_WIDTH, 8, FIFO word width; must match the FIFO's DATA_WIDTH.
- CNT_WIDTH, 16, width of the popped-word counter.

Ports:
- rclk  input  1  read-domain clock; all state updates on posedge.
- rrst_n  input  1  asynchronous active-low reset for the read domain.
- rd_en  input  1  permission to pop; when 0, no new rinc is issued.
- rempty  input  1  FIFO empty flag, already in the rclk domain.
- rdata  input  DATA_WIDTH  FIFO head word; valid whenever rempty=0; advances after a cycle with rinc=1.
- rinc  output  1  pop strobe to the FIFO.
- m_valid  output  1  stream word valid.
- m_data  output  DATA_WIDTH  stream word.
- m_ready  input  1  downstream accept.
- rd_count  output  CNT_WIDTH  total words popped since reset; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset: clock is rclk; reset is rrst_n, asynchronous assert, active-low. While rrst_n=0:
  - rinc=0, m_valid=0, m_data=0, rd_count=0.
  - Skid buffer occupancy occ=0 and both slots zeroed.
- Storage: occ in {0,1,2}. slot0 is the head and drives m_data; slot1 is the skid entry. m_valid = (occ!=0).
- Pop rule: rinc = rd_en & ~rempty & (occ!=2).
  - rinc depends only on rd_en, rempty and registered occ, never on m_ready.
  - No pop when occ==2, even if m_ready=1 in the same cycle.
- Push: on a posedge with rinc=1, rdata is captured as the new word in that same edge. Latency is 1 cycle: a word at the FIFO head with rempty=0 and occ=0 appears on m_data with m_valid=1 on the next cycle.
- Drain: deq = m_valid & m_ready.
- Next-state table:
  - occ0, push: slot0 = rdata, occ becomes 1.
  - occ1, push, no deq: slot1 = rdata, occ becomes 2.
  - occ1, push, deq: slot0 = rdata, occ stays 1.
  - occ1, deq, no push: occ becomes 0.
  - occ2, deq: slot0 = slot1, occ becomes 1 (no push possible).
  - Any other combination holds state.
- Stream rule: when m_valid=1 and m_ready=0, m_data stays stable and m_valid stays asserted (standard valid/ready).
- Throughput: with rd_en=1, FIFO non-empty and m_ready=1 continuously, one word per cycle.
- rd_count: increments by 1 on every posedge with rinc=1; wraps from 2^CNT_WIDTH-1 to 0.
- rd_en deassert: buffered words still drain normally; only new pops stop.
- rempty rises mid-stream: rinc drops in the same cycle; the buffer drains normally.
- Reset mid-operation: buffered words are discarded without being emitted, and rinc drops immediately (asynchronously).
- Ordering: words leave in FIFO order; none are duplicated or lost outside of reset.

Decomposition:
- Package afifo_pkg:
  - DATA_WIDTH default constant.
  - typedef afifo_word_t (logic [DATA_WIDTH-1:0]).
  - typedef occ_t (logic [1:0]).
- Sub-module afifo_skid_buf: the 2-entry buffer with push/data_in, m_valid/m_data/m_ready, and occ output.
- afifo_reader instantiates afifo_skid_buf and adds the rinc logic and rd_count.

Test Plan:
- Reset then idle: rrst_n=0 for 3 cycles, rempty=1 → rinc=0, m_valid=0, m_data=0, rd_count=0 throughout.
- Streaming: FIFO holds 0x11,0x22,0x33, rd_en=1, m_ready=1 → rinc high 3 consecutive cycles; m_data 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after the first rinc; rd_count=3.
- Backpressure: m_ready=0, 4 words available → exactly 2 rinc pulses, occ=2, m_data holds first word. Raise m_ready → all 4 words emitted in order, each accepted in the cycle it is presented, no gaps.
- rd_en gating: occ=1 with word 0xA5 buffered, rd_en=0, rempty=0, m_ready=1 → 0xA5 emitted once, then m_valid=0; rinc stays 0 until rd_en=1.
- Reset mid-operation: occ=2 holding 0x01,0x02, assert rrst_n=0 → m_valid and rinc go 0 immediately; after release, rd_count=0 and neither word is emitted.
- Counter wrap: CNT_WIDTH=4, 17 pops → rd_count=1.
